// File: rtl/int_root.sv
// Iterative n-th root, out = floor(inx^(1/inn)); binary search over 16 bits, square-and-multiply per candidate.
// Latency fixed by inn (inn 0/1: ready back in the 3rd cycle); start ignored while busy, nothing queued.
module int_root (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] inx,
    input  logic [7:0]  inn,
    output logic        ready,
    output logic [15:0] out,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISPATCH,
        S_BIT,
        S_POW,
        S_CMP,
        S_DONE
    } state_t;

    state_t      state, state_n;
    logic [15:0] x_q, x_n;
    logic [7:0]  n_q, n_n;
    logic [15:0] root_q, root_n;
    logic [15:0] cand_q, cand_n;
    logic [3:0]  b_q, b_n;
    logic [16:0] pw_q, pw_n;
    logic [16:0] base_q, base_n;
    logic [7:0]  e_q, e_n;
    logic        res_err_q, res_err_n;
    logic [15:0] out_n;
    logic        err_n;

    // 17'h10000 stands for "anything above 16 bits"; once reached it never shrinks.
    function automatic logic [16:0] sat_mul(input logic [16:0] a, input logic [16:0] b);
        logic [33:0] p;
        p = {17'd0, a} * {17'd0, b};
        if (a[16] || b[16] || (p > 34'h0_FFFF))
            return 17'h10000;
        return p[16:0];
    endfunction

    assign ready = (state == S_IDLE);

    always_comb begin
        state_n   = state;
        x_n       = x_q;
        n_n       = n_q;
        root_n    = root_q;
        cand_n    = cand_q;
        b_n       = b_q;
        pw_n      = pw_q;
        base_n    = base_q;
        e_n       = e_q;
        res_err_n = res_err_q;
        out_n     = out;
        err_n     = err;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    x_n     = inx;
                    n_n     = inn;
                    state_n = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                res_err_n = 1'b0;
                root_n    = 16'd0;
                if (n_q == 8'd0) begin
                    res_err_n = 1'b1;
                    state_n   = S_DONE;
                end else if (n_q == 8'd1) begin
                    root_n  = x_q;
                    state_n = S_DONE;
                end else begin
                    b_n     = 4'd15;
                    state_n = S_BIT;
                end
            end
            S_BIT: begin
                cand_n  = root_q | (16'd1 << b_q);
                pw_n    = 17'd1;
                base_n  = {1'b0, cand_n};
                e_n     = n_q;
                state_n = S_POW;
            end
            S_POW: begin
                if (e_q == 8'd0) begin
                    state_n = S_CMP;
                end else if (e_q[0]) begin
                    pw_n = sat_mul(pw_q, base_q);
                    e_n  = e_q - 8'd1;
                end else begin
                    base_n = sat_mul(base_q, base_q);
                    e_n    = e_q >> 1;
                end
            end
            S_CMP: begin
                if (pw_q <= {1'b0, x_q})
                    root_n = cand_q;
                if (b_q == 4'd0) begin
                    state_n = S_DONE;
                end else begin
                    b_n     = b_q - 4'd1;
                    state_n = S_BIT;
                end
            end
            S_DONE: begin
                out_n   = root_q;
                err_n   = res_err_q;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            x_q       <= 16'd0;
            n_q       <= 8'd0;
            root_q    <= 16'd0;
            cand_q    <= 16'd0;
            b_q       <= 4'd0;
            pw_q      <= 17'd0;
            base_q    <= 17'd0;
            e_q       <= 8'd0;
            res_err_q <= 1'b0;
            out       <= 16'd0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            x_q       <= x_n;
            n_q       <= n_n;
            root_q    <= root_n;
            cand_q    <= cand_n;
            b_q       <= b_n;
            pw_q      <= pw_n;
            base_q    <= base_n;
            e_q       <= e_n;
            res_err_q <= res_err_n;
            out       <= out_n;
            err       <= err_n;
        end
    end

endmodule

// File: tb/tb_int_root.sv
// Bench for int_root: driver pushes expected results into a queue, a negedge monitor pops on each ready rise.
module tb_int_root;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] inx = 16'd0;
    logic [7:0]  inn = 8'd0;
    logic        ready;
    logic [15:0] out;
    logic        err;

    int_root dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .inx   (inx),
        .inn   (inn),
        .ready (ready),
        .out   (out),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] o;
        logic        e;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    exp_t        cur;
    int          vectors = 0;
    int          miscompares = 0;
    logic        rst_e = 1'b1;
    logic [15:0] held_out = 16'd0;
    logic        held_err = 1'b0;
    logic        prev_rdy = 1'b1;
    int          busy = 0;

    // Largest r with r^n <= x, found by counting upward.
    function automatic int ref_root(input int x, input int n);
        int     r;
        longint p;
        bit     over;
        if (n == 0) return 0;
        if (n == 1) return x;
        r = 0;
        forever begin
            p = 1;
            over = 0;
            for (int i = 0; i < n; i++) begin
                p = p * (r + 1);
                if (p > x) begin
                    over = 1;
                    break;
                end
            end
            if (over) return r;
            r++;
        end
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) rst_e = rst;

    always @(negedge clk) begin
        if (rst_e) begin
            check("rst_ready", ready, 1);
            check("rst_out", out, 0);
            check("rst_err", err, 0);
            held_out = 16'd0;
            held_err = 1'b0;
            busy = 0;
        end else if (!ready) begin
            busy++;
            check("hold_out", out, held_out);
            check("hold_err", err, held_err);
            if (busy == 400) begin
                miscompares++;
                $display("FAIL busy_timeout: ready still 0 after %0d cycles, expected 1", busy);
            end
        end else if (!prev_rdy) begin
            if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: result out=%0d with no request pending", out);
            end else begin
                cur = sbq.pop_front();
                check("result_out", out, cur.o);
                check("result_err", err, cur.e);
                if (cur.lat != 0) check("latency", busy + 1, cur.lat);
                held_out = cur.o;
                held_err = cur.e;
            end
            busy = 0;
        end
        prev_rdy = ready;
    end

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (!ready) begin
            miscompares++;
            $display("FAIL wait_ready: ready=0 after %0d cycles, expected 1", k);
        end
    endtask

    function automatic exp_t mk_exp(input int x, input int n);
        exp_t t;
        t.o   = 16'(ref_root(x, n));
        t.e   = (n == 0);
        t.lat = (n <= 1) ? 3 : 0;
        return t;
    endfunction

    task automatic issue(input int x, input int n);
        wait_ready();
        inx   = 16'(x);
        inn   = 8'(n);
        start = 1'b1;
        sbq.push_back(mk_exp(x, n));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Follows a long job: requests while busy must not disturb it.
    task automatic busy_poke();
        for (int i = 0; i < 6; i++) begin
            inx   = 16'($urandom_range(0, 65535));
            inn   = 8'($urandom_range(0, 255));
            start = i[0];
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Second request held high across the completion of the first.
    task automatic back_to_back(input int xa, input int na, input int xb, input int nb);
        int k;
        issue(xa, na);
        repeat (3) @(negedge clk);
        inx   = 16'(xb);
        inn   = 8'(nb);
        start = 1'b1;
        sbq.push_back(mk_exp(xb, nb));
        k = 0;
        while (!ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_after_idle", ready, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        issue(1000, 3);
        issue(999, 3);
        issue(65535, 2);
        issue(65535, 16);
        issue(12345, 1);
        issue(77, 0);
        issue(16, 4);
        issue(0, 5);
        issue(1, 255);
        issue(65535, 1);
        issue(59049, 10);

        issue(40000, 2);
        busy_poke();
        issue(32768, 15);
        busy_poke();

        back_to_back(50000, 5, 2000, 3);

        for (int i = 0; i < 20; i++)
            issue($urandom_range(0, 65535), $urandom_range(2, 20));

        // Abort a job while it is inside the power loop.
        issue(60000, 20);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;

        // Reset and start on the same edge: start must be dropped.
        wait_ready();
        rst   = 1'b1;
        start = 1'b1;
        inx   = 16'd500;
        inn   = 8'd2;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_not_accepted", ready, 1);

        issue(81, 4);
        wait_ready();
        @(negedge clk);
        check("queue_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
